// File: rtl/captura_operandos_alu_if.sv
// Bus between the operand-capture front-end and its surroundings:
// switch/button inputs, the ALU result coming back, and the registered
// operands, result and status going out.
interface captura_operandos_alu_if #(
    parameter int n_bits         = 8,
    parameter int ancho_contador = 8
);
    logic [n_bits-1:0]         datos;
    logic                      cargar;
    logic                      deshacer;
    logic                      encadenar;
    logic [n_bits-1:0]         resultado_alu;
    logic [n_bits-1:0]         entrada_a;
    logic [n_bits-1:0]         entrada_b;
    logic [1:0]                operacion;
    logic [n_bits-1:0]         resultado;
    logic                      listo;
    logic [2:0]                estado;
    logic [ancho_contador-1:0] contador_ops;

    // Board / ALU side: drives switches, strobes and the ALU result.
    modport master (
        output datos, cargar, deshacer, encadenar, resultado_alu,
        input  entrada_a, entrada_b, operacion, resultado, listo, estado, contador_ops
    );

    // Capture front-end side.
    modport slave (
        input  datos, cargar, deshacer, encadenar, resultado_alu,
        output entrada_a, entrada_b, operacion, resultado, listo, estado, contador_ops
    );
endinterface

// File: rtl/captura_operandos_alu.sv
// Operand capture front-end for the generalized ALU. Collects A, B and the
// op code one strobe at a time, latches the ALU result for display, and
// supports undo of the last capture and chaining of the result into A.
module captura_operandos_alu #(
    parameter int n_bits         = 8,
    parameter int ancho_contador = 8
) (
    input logic                    clk,
    input logic                    resetN,
    captura_operandos_alu_if.slave bus
);
    localparam logic [2:0] ESPERA_A  = 3'b000;
    localparam logic [2:0] ESPERA_B  = 3'b001;
    localparam logic [2:0] ESPERA_OP = 3'b010;
    localparam logic [2:0] CALCULO   = 3'b011;
    localparam logic [2:0] MOSTRAR   = 3'b100;

    logic [2:0]                state_q, state_d;
    logic [n_bits-1:0]         a_q, a_d;
    logic [n_bits-1:0]         b_q, b_d;
    logic [1:0]                op_q, op_d;
    logic [n_bits-1:0]         res_q, res_d;
    logic                      listo_q, listo_d;
    logic [ancho_contador-1:0] cnt_q, cnt_d;

    // Undo wins over load when both strobes arrive together.
    logic captura;
    assign captura = bus.cargar && !bus.deshacer;

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ESPERA_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; unused encodings fall back to ESPERA_A.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ESPERA_A: begin
                if (captura) state_d = ESPERA_B;
            end
            ESPERA_B: begin
                if (bus.deshacer)    state_d = ESPERA_A;
                else if (bus.cargar) state_d = ESPERA_OP;
            end
            ESPERA_OP: begin
                if (bus.deshacer)    state_d = ESPERA_B;
                else if (bus.cargar) state_d = CALCULO;
            end
            CALCULO: begin
                state_d = MOSTRAR;
            end
            MOSTRAR: begin
                if (bus.deshacer)    state_d = ESPERA_OP;
                else if (bus.cargar) state_d = bus.encadenar ? ESPERA_B : ESPERA_A;
            end
            default: begin
                state_d = ESPERA_A;
            end
        endcase
    end

    // Output/datapath next values: every register holds unless its capture fires.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        listo_d = 1'b0;
        case (state_q)
            ESPERA_A: begin
                if (captura) a_d = bus.datos;
            end
            ESPERA_B: begin
                if (captura) b_d = bus.datos;
            end
            ESPERA_OP: begin
                if (captura) op_d = bus.datos[1:0];
            end
            CALCULO: begin
                // Operands are registered, so the ALU output is already settled here.
                res_d   = bus.resultado_alu;
                listo_d = 1'b1;
                cnt_d   = cnt_q + ancho_contador'(1);
            end
            MOSTRAR: begin
                if (captura && bus.encadenar) a_d = res_q;
            end
            default: begin
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            res_q   <= '0;
            listo_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            listo_q <= listo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.entrada_a    = a_q;
    assign bus.entrada_b    = b_q;
    assign bus.operacion    = op_q;
    assign bus.resultado    = res_q;
    assign bus.listo        = listo_q;
    assign bus.estado       = state_q;
    assign bus.contador_ops = cnt_q;
endmodule
